y86_mem_arbiter: RTL and testbench

//   Shares the single y86 memory bus (bus_A/bus_in/bus_out/bus_WE/bus_RE) between two masters:
//   M0 = y86_seq core, M1 = DMA/debug loader. Requests use a req/gnt/done handshake.

---
 rtl/y86_arb_pkg.sv | 21 ++
 rtl/y86_arb_pick.sv | 44 ++++
 rtl/y86_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_y86_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_arb_pkg.sv
// ---------------------------------------------------------------------------
// y86_arb_pkg
//   Shared types and constants for the y86 memory bus arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   - M0 / M1     : requester ids (M0 = y86_seq core, M1 = DMA/debug loader)
//   - MAX_WAIT    : largest supported number of extra bus cycles per access
// ---------------------------------------------------------------------------
package y86_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int MAX_WAIT = 15;

endpackage

// File: rtl/y86_arb_pick.sv
// ---------------------------------------------------------------------------
// y86_arb_pick
//   Combinational winner selection between the two bus masters.
//   Build option: Y86_ARB_RR_EN
//     undefined : fixed priority, M0 wins when both request (M1 can starve)
//     defined   : round-robin, the master that was not the last owner wins
//                 when both request; a lone request always wins
// Ports
//   req[1:0]   in   request lines, bit 0 = M0, bit 1 = M1
//   last_owner in   owner of the most recent grant
//   valid      out  at least one request is pending
//   winner     out  id of the selected master (meaningful when valid)
// ---------------------------------------------------------------------------
module y86_arb_pick
    import y86_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    assign valid = |req;

`ifdef Y86_ARB_RR_EN
    // On contention hand the bus to whoever did not have it last time.
    always_comb begin
        if (req[0] && req[1]) begin
            winner = ~last_owner;
        end else if (req[1]) begin
            winner = M1;
        end else begin
            winner = M0;
        end
    end
`else
    // History is irrelevant under fixed priority; tie it off by name.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    assign winner = req[0] ? M0 : M1;
`endif

endmodule

// File: rtl/y86_mem_arbiter.sv
// ---------------------------------------------------------------------------
// y86_mem_arbiter
//   Shares the single y86 memory bus between M0 (y86_seq core) and M1
//   (DMA/debug loader) with a req/gnt/done handshake. Each access owns the
//   bus for WAIT_STATES+1 cycles, followed by a one-cycle done pulse.
//   Build option: Y86_ARB_RR_EN selects round-robin instead of fixed
//   priority (see y86_arb_pick).
// Parameters
//   AW, DW       address / data width
//   WAIT_STATES  extra bus cycles per access (0..MAX_WAIT)
// Ports
//   clk, rst                      clock, async active-high reset
//   mN_req/we/addr/wdata  in      master N request and its operands
//   mN_gnt                out     master N owns the bus (ACCESS, RESP)
//   mN_done               out     one-cycle completion pulse
//   mN_rdata              out     registered read data for master N
//   bus_A/bus_out/bus_WE/bus_RE   memory bus, driven only in ACCESS
//   bus_in                in      memory read data, valid on last ACCESS cycle
// ---------------------------------------------------------------------------
module y86_mem_arbiter
    import y86_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] bus_A,
    output logic [DW-1:0] bus_out,
    output logic          bus_WE,
    output logic          bus_RE,
    input  logic [DW-1:0] bus_in
);

    // Out-of-range settings are clamped so the counter width stays sane.
    localparam int WS = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT :
                        ((WAIT_STATES < 0) ? 0 : WAIT_STATES);
    localparam int CW = (WS > 0) ? $clog2(WS + 1) : 1;

    arb_state_t    state;
    arb_state_t    next_state;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          pick_valid;
    logic          pick_winner;
    logic          grant;
    logic          last_cycle;

    // The owner register doubles as the round-robin history: both reset to
    // M0 and both change exactly on IDLE->ACCESS.
    y86_arb_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_owner (owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign grant      = (state == IDLE) && pick_valid;
    assign last_cycle = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid) next_state = ACCESS;
            ACCESS:  if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands are latched at grant so requester changes mid-access are
    // ignored; read data lands in the owner's register on the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= M0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            if (grant) begin
                owner   <= pick_winner;
                we_q    <= (pick_winner == M1) ? m1_we    : m0_we;
                addr_q  <= (pick_winner == M1) ? m1_addr  : m0_addr;
                wdata_q <= (pick_winner == M1) ? m1_wdata : m0_wdata;
                cnt     <= CW'(WS);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (last_cycle && !we_q) begin
                if (owner == M1) begin
                    m1_rdata <= bus_in;
                end else begin
                    m0_rdata <= bus_in;
                end
            end
        end
    end

    // Outputs decode straight from state so an async reset drops the bus
    // without waiting for a clock edge.
    always_comb begin
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        m0_done = 1'b0;
        m1_done = 1'b0;
        bus_A   = '0;
        bus_out = '0;
        bus_WE  = 1'b0;
        bus_RE  = 1'b0;
        case (state)
            ACCESS: begin
                m0_gnt = (owner == M0);
                m1_gnt = (owner == M1);
                bus_A  = addr_q;
                bus_WE = we_q;
                bus_RE = !we_q;
                if (we_q) bus_out = wdata_q;
            end
            RESP: begin
                m0_gnt  = (owner == M0);
                m1_gnt  = (owner == M1);
                m0_done = (owner == M0);
                m1_done = (owner == M1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_y86_mem_arbiter
//   Scoreboard bench for y86_mem_arbiter with WAIT_STATES=3. Expected
//   accesses are queued in service order when requests are driven; a
//   negedge monitor checks bus contents against the queue head and pops it
//   on each done pulse. Honors Y86_ARB_RR_EN for the arbitration model.
// ---------------------------------------------------------------------------
module tb_y86_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WS = 3;
`ifdef Y86_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_gnt, m0_done;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_done;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] bus_A;
    logic [DW-1:0] bus_out, bus_in;
    logic          bus_WE, bus_RE;

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model_mem [256];
    logic [31:0] mem [256];
    bit          written [256];
    bit          model_last;
    int          n_checks = 0;
    int          n_errors = 0;
    int          run_len = 0;

    always #5 clk = ~clk;

    y86_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_done  (m0_done),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_done  (m1_done),
        .m1_rdata (m1_rdata),
        .bus_A    (bus_A),
        .bus_out  (bus_out),
        .bus_WE   (bus_WE),
        .bus_RE   (bus_RE),
        .bus_in   (bus_in)
    );

    function automatic logic [31:0] init_pattern(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {8'hC0, a, ~a, 8'h5A};
    endfunction

    // Simple memory: unwritten locations return a fixed address pattern.
    assign bus_in = written[bus_A[7:0]] ? mem[bus_A[7:0]] : init_pattern(bus_A[7:0]);

    always @(posedge clk) begin
        if (!rst && bus_WE) begin
            mem[bus_A[7:0]]     <= bus_out;
            written[bus_A[7:0]] <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Queue one expected access, in the order the arbiter should serve it.
    task automatic pushExpect(input bit m, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        exp_t e;
        e.m    = m;
        e.we   = we;
        e.addr = addr;
        if (we) begin
            e.data = wdata;
            model_mem[addr[7:0]] = wdata;
        end else begin
            e.data = model_mem[addr[7:0]];
        end
        model_last = m;
        sb.push_back(e);
    endtask

    function automatic bit modelWinner(input bit r0, input bit r1);
        if (r0 && r1) return RR ? ~model_last : 1'b0;
        return r1 && !r0;
    endfunction

    task automatic applyStimulus(input bit m, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (m) begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end
    endtask

    task automatic dropReq(input bit m);
        if (m) m1_req = 1'b0;
        else   m0_req = 1'b0;
    endtask

    task automatic waitDone(input bit m, input bit hold, output int cycles, output bit other_gnt);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        other_gnt = 1'b0;
        while (!seen && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            if (m ? m0_gnt : m1_gnt) other_gnt = 1'b1;
            seen = m ? m1_done : m0_done;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (!hold) dropReq(m);
    endtask

    task automatic waitAny(output int cycles, output bit who);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        who = 1'b0;
        while (!seen && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            seen = m0_done | m1_done;
            who  = m1_done;
        end
        checkOutput("any_done_seen", 32'(seen), 32'd1);
    endtask

    // Negedge monitor: bus contents vs queue head, run length, done/rdata.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else begin
            checkOutput("gnt_excl", 32'(m0_gnt & m1_gnt), 32'd0);
            if (bus_RE || bus_WE) begin
                run_len++;
                if (sb.size() == 0) begin
                    checkOutput("bus_unexp", 32'(bus_RE | bus_WE), 32'd0);
                end else begin
                    checkOutput("bus_A", bus_A, sb[0].addr);
                    checkOutput("bus_WE", 32'(bus_WE), 32'(sb[0].we));
                    if (sb[0].we) checkOutput("bus_out", bus_out, sb[0].data);
                    checkOutput("gnt_owner", 32'(sb[0].m ? m1_gnt : m0_gnt), 32'd1);
                end
            end else begin
                checkOutput("bus_A_idle", bus_A, 32'd0);
                checkOutput("bus_out_idle", bus_out, 32'd0);
                if (run_len != 0) checkOutput("bus_len", 32'(run_len), 32'(WS + 1));
                run_len = 0;
            end
            if (m0_done || m1_done) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_done", 32'({m1_done, m0_done}), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("done_owner", 32'({m1_done, m0_done}), mon_e.m ? 32'd2 : 32'd1);
                    if (!mon_e.we) checkOutput("rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        int cyc;
        bit og;
        int gap;
        bit who;
        bit w;
        bit exp_who [4];

        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        model_last = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = init_pattern(8'(i));

        @(posedge clk); #1;
        checkOutput("rst_ctrl", 32'({bus_WE, bus_RE, m0_gnt, m1_gnt, m0_done, m1_done}), 32'd0);
        checkOutput("rst_bus_A", bus_A, 32'd0);
        checkOutput("rst_bus_out", bus_out, 32'd0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
        checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single read by M0
        pushExpect(1'b0, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
        waitDone(1'b0, 1'b0, cyc, og);
        checkOutput("t1_latency", 32'(cyc), 32'(WS + 2));
        checkOutput("t1_other_gnt", 32'(og), 32'd0);
        checkOutput("t1_rdata", m0_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // M1 write, then M0 reads it back
        pushExpect(1'b1, 1'b1, 32'h20, 32'h55AA);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h55AA);
        waitDone(1'b1, 1'b0, cyc, og);
        checkOutput("t2_latency", 32'(cyc), 32'(WS + 2));
        checkOutput("t2_m0_gnt", 32'(og), 32'd0);
        @(posedge clk); #1;
        pushExpect(1'b0, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0);
        waitDone(1'b0, 1'b0, cyc, og);
        checkOutput("t2_readback", m0_rdata, 32'h55AA);
        @(posedge clk); #1;

        // Both request together
        w = modelWinner(1'b1, 1'b1);
        pushExpect(w, 1'b0, w ? 32'h31 : 32'h30, 32'h0);
        pushExpect(~w, 1'b0, w ? 32'h30 : 32'h31, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h30, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h31, 32'h0);
        waitDone(w, 1'b0, cyc, og);
        checkOutput("t3_first_latency", 32'(cyc), 32'(WS + 2));
        waitDone(~w, 1'b0, cyc, og);
        checkOutput("t3_second_gap", 32'(cyc), 32'(WS + 3));
        checkOutput("t3_other_gnt", 32'(og), 32'd0);
        @(posedge clk); #1;

        // Both held for four accesses
        for (int k = 0; k < 4; k++) begin
            exp_who[k] = modelWinner(1'b1, 1'b1);
            pushExpect(exp_who[k], 1'b0, exp_who[k] ? 32'h41 : 32'h40, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h41, 32'h0);
        for (int k = 0; k < 4; k++) begin
            waitAny(cyc, who);
            checkOutput("t4_owner", 32'(who), 32'(exp_who[k]));
            checkOutput("t4_spacing", 32'(cyc), (k == 0) ? 32'(WS + 2) : 32'(WS + 3));
        end
        dropReq(1'b0);
        dropReq(1'b1);
        @(posedge clk); #1;

        // Request held one cycle past done starts a second access
        pushExpect(1'b0, 1'b0, 32'h50, 32'h0);
        pushExpect(1'b0, 1'b0, 32'h50, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h50, 32'h0);
        waitDone(1'b0, 1'b1, cyc, og);
        gap = 0;
        while (!bus_RE && gap < 10) begin
            gap++;
            @(posedge clk); #1;
        end
        dropReq(1'b0);
        checkOutput("t6_gap", 32'(gap), 32'd2);
        waitDone(1'b0, 1'b0, cyc, og);
        checkOutput("t6_second_rest", 32'(cyc), 32'(WS + 1));
        @(posedge clk); #1;

        // Reset in the second ACCESS cycle of an M1 write
        pushExpect(1'b1, 1'b1, 32'h60, 32'h1234);
        applyStimulus(1'b1, 1'b1, 32'h60, 32'h1234);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("t5_we_before", 32'(bus_WE), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_we_async", 32'(bus_WE), 32'd0);
        checkOutput("t5_re_async", 32'(bus_RE), 32'd0);
        checkOutput("t5_gnt_async", 32'({m0_gnt, m1_gnt}), 32'd0);
        checkOutput("t5_m0_rdata", m0_rdata, 32'd0);
        checkOutput("t5_m1_rdata", m1_rdata, 32'd0);
        sb.delete();
        dropReq(1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput("t5_quiet", 32'({m0_gnt, m1_gnt, m0_done, m1_done}), 32'd0);
        end
        pushExpect(1'b0, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
        waitDone(1'b0, 1'b0, cyc, og);
        checkOutput("t5_after_latency", 32'(cyc), 32'(WS + 2));
        checkOutput("t5_after_rdata", m0_rdata, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
